// File: rtl/wb_bus_arbiter_pkg.sv
// rtl/wb_bus_arbiter_pkg.sv - shared encodings and helpers for the two-port Wishbone arbiter
package wb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        LS_NONE = 2'd0,
        LS_I    = 2'd1,
        LS_D    = 2'd2
    } last_served_t;

    localparam logic [3:0] SEL_ALL = 4'hF;

    // A disabled watchdog still needs a one-bit counter to stay legal.
    function automatic int unsigned wdog_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - instruction, data and system bus signals of the arbiter
interface wb_bus_arbiter_if;
    logic        iwbs_cyc_i;
    logic        iwbs_stb_i;
    logic [31:0] iwbs_addr_i;
    logic [31:0] iwbs_dat_o;
    logic        iwbs_ack_o;
    logic        iwbs_err_o;
    logic        dwbs_cyc_i;
    logic        dwbs_stb_i;
    logic        dwbs_we_i;
    logic [3:0]  dwbs_sel_i;
    logic [31:0] dwbs_addr_i;
    logic [31:0] dwbs_dat_i;
    logic [31:0] dwbs_dat_o;
    logic        dwbs_ack_o;
    logic        dwbs_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_addr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        timeout_o;

    modport master (
        input  iwbs_cyc_i, iwbs_stb_i, iwbs_addr_i,
        output iwbs_dat_o, iwbs_ack_o, iwbs_err_o,
        input  dwbs_cyc_i, dwbs_stb_i, dwbs_we_i, dwbs_sel_i, dwbs_addr_i, dwbs_dat_i,
        output dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output timeout_o
    );

    modport slave (
        output iwbs_cyc_i, iwbs_stb_i, iwbs_addr_i,
        input  iwbs_dat_o, iwbs_ack_o, iwbs_err_o,
        output dwbs_cyc_i, dwbs_stb_i, dwbs_we_i, dwbs_sel_i, dwbs_addr_i, dwbs_dat_i,
        input  dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  timeout_o
    );
endinterface

// File: rtl/wb_bus_arbiter_watchdog.sv
// rtl/wb_bus_arbiter_watchdog.sv - grant-cycle counter that flags a hung bus transfer
module wb_watchdog
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned   W     = wdog_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0]  LIMIT = W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (count_q == LIMIT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin arbiter merging instruction and data Wishbone ports onto one bus
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES   = 255,
    parameter bit          FIRST_PRIORITY_D = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_bus_arbiter_if.master bus
);
    arb_state_t   state_q, state_d;
    last_served_t ls_q, ls_d;

    logic req_i, req_d;
    logic gnt_i, gnt_d;
    logic active_i, active_d, active;
    logic bus_done, expire;

    assign req_i    = bus.iwbs_cyc_i & bus.iwbs_stb_i;
    assign req_d    = bus.dwbs_cyc_i & bus.dwbs_stb_i;
    assign gnt_i    = (state_q == ST_GNT_I);
    assign gnt_d    = (state_q == ST_GNT_D);
    // A granted port that drops cyc aborts: nothing is forwarded to it from then on.
    assign active_i = gnt_i & bus.iwbs_cyc_i;
    assign active_d = gnt_d & bus.dwbs_cyc_i;
    assign active   = active_i | active_d;
    assign bus_done = bus.wbm_ack_i | bus.wbm_err_i;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q == ST_IDLE),
        .en_i     (active & ~bus_done),
        .expire_o (expire)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ls_q    <= LS_NONE;
        end else begin
            state_q <= state_d;
            ls_q    <= ls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ls_d    = ls_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i && req_d) begin
                    if (ls_q == LS_I)      state_d = ST_GNT_D;
                    else if (ls_q == LS_D) state_d = ST_GNT_I;
                    else                   state_d = FIRST_PRIORITY_D ? ST_GNT_D : ST_GNT_I;
                end else if (req_i) begin
                    state_d = ST_GNT_I;
                end else if (req_d) begin
                    state_d = ST_GNT_D;
                end
            end
            ST_GNT_I: begin
                if (!bus.iwbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (bus_done || expire) begin
                    state_d = ST_IDLE;
                    ls_d    = LS_I;
                end
            end
            ST_GNT_D: begin
                if (!bus.dwbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (bus_done || expire) begin
                    state_d = ST_IDLE;
                    ls_d    = LS_D;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.wbm_cyc_o  = active & ~expire;
    assign bus.wbm_stb_o  = ((active_i & bus.iwbs_stb_i) | (active_d & bus.dwbs_stb_i)) & ~expire;
    assign bus.wbm_we_o   = gnt_d & bus.dwbs_we_i;
    assign bus.wbm_sel_o  = gnt_d ? bus.dwbs_sel_i  : (gnt_i ? SEL_ALL : 4'h0);
    assign bus.wbm_addr_o = gnt_d ? bus.dwbs_addr_i : (gnt_i ? bus.iwbs_addr_i : 32'h0);
    assign bus.wbm_dat_o  = gnt_d ? bus.dwbs_dat_i  : 32'h0;

    assign bus.iwbs_dat_o = bus.wbm_dat_i;
    assign bus.dwbs_dat_o = bus.wbm_dat_i;
    assign bus.iwbs_ack_o = active_i & bus.wbm_ack_i;
    assign bus.dwbs_ack_o = active_d & bus.wbm_ack_i;
    assign bus.iwbs_err_o = active_i & (bus.wbm_err_i | expire);
    assign bus.dwbs_err_o = active_d & (bus.wbm_err_i | expire);
    assign bus.timeout_o  = expire;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb_bus_arbiter_if bus ();

    wb_bus_arbiter #(
        .TIMEOUT_CYCLES   (4),
        .FIRST_PRIORITY_D (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] IADDR = 32'h8000_0000;
    localparam logic [31:0] DADDR = 32'h1000_0004;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.iwbs_cyc_i  = 1'b0;
        bus.iwbs_stb_i  = 1'b0;
        bus.iwbs_addr_i = IADDR;
        bus.dwbs_cyc_i  = 1'b0;
        bus.dwbs_stb_i  = 1'b0;
        bus.dwbs_we_i   = 1'b0;
        bus.dwbs_sel_i  = 4'h0;
        bus.dwbs_addr_i = DADDR;
        bus.dwbs_dat_i  = 32'h0;
        bus.wbm_dat_i   = 32'h0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
    endtask

    task automatic set_req_i(input logic v);
        bus.iwbs_cyc_i = v;
        bus.iwbs_stb_i = v;
    endtask

    task automatic set_req_d(input logic v);
        bus.dwbs_cyc_i = v;
        bus.dwbs_stb_i = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();

        // reset state
        sample();
        check("rst_cyc", {31'b0, bus.wbm_cyc_o}, 32'h0);
        check("rst_stb", {31'b0, bus.wbm_stb_o}, 32'h0);
        check("rst_sel", {28'b0, bus.wbm_sel_o}, 32'h0);
        check("rst_addr", bus.wbm_addr_o, 32'h0);
        check("rst_acks", {29'b0, bus.iwbs_ack_o, bus.dwbs_ack_o, bus.timeout_o}, 32'h0);
        step();
        rst_n = 1'b1;

        // ack in IDLE is ignored
        step();
        bus.wbm_ack_i = 1'b1;
        sample();
        check("idle_ack_ignored", {30'b0, bus.iwbs_ack_o, bus.dwbs_ack_o}, 32'h0);
        step();
        bus.wbm_ack_i = 1'b0;

        // instruction-only read, ack on the second grant cycle
        set_req_i(1'b1);
        sample();
        check("i_rd_idle_cyc", {31'b0, bus.wbm_cyc_o}, 32'h0);
        step();
        sample();
        check("i_rd_gnt_cyc", {30'b0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h3);
        check("i_rd_addr", bus.wbm_addr_o, IADDR);
        check("i_rd_we_sel", {27'b0, bus.wbm_we_o, bus.wbm_sel_o}, 32'h0000_000F);
        check("i_rd_no_ack_yet", {31'b0, bus.iwbs_ack_o}, 32'h0);
        step();
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h0000_0013;
        sample();
        check("i_rd_ack", {30'b0, bus.iwbs_ack_o, bus.dwbs_ack_o}, 32'h2);
        check("i_rd_dat", bus.iwbs_dat_o, 32'h0000_0013);
        step();
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        set_req_i(1'b0);
        sample();
        check("i_rd_done_idle", {30'b0, bus.wbm_cyc_o, bus.iwbs_ack_o}, 32'h0);

        // simultaneous requests straight after reset: data first
        do_reset();
        set_req_i(1'b1);
        set_req_d(1'b1);
        step();
        sample();
        check("both_first_d", bus.wbm_addr_o, DADDR);
        step();
        bus.wbm_ack_i = 1'b1;
        sample();
        check("both_d_ack", {30'b0, bus.iwbs_ack_o, bus.dwbs_ack_o}, 32'h1);
        step();
        bus.wbm_ack_i = 1'b0;
        set_req_d(1'b0);
        sample();
        check("both_gap_idle", {31'b0, bus.wbm_cyc_o}, 32'h0);
        step();
        sample();
        check("both_then_i", bus.wbm_addr_o, IADDR);
        step();
        bus.wbm_ack_i = 1'b1;
        sample();
        check("both_i_ack", {30'b0, bus.iwbs_ack_o, bus.dwbs_ack_o}, 32'h2);
        step();
        bus.wbm_ack_i = 1'b0;
        set_req_i(1'b0);

        // six back-to-back transfers with both held: D,I,D,I,D,I
        set_req_i(1'b1);
        set_req_d(1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            bus.wbm_ack_i = 1'b1;
            sample();
            check($sformatf("rr_addr_%0d", k), bus.wbm_addr_o, (k % 2 == 0) ? DADDR : IADDR);
            check($sformatf("rr_ack_%0d", k), {30'b0, bus.iwbs_ack_o, bus.dwbs_ack_o},
                  (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            bus.wbm_ack_i = 1'b0;
            sample();
            check($sformatf("rr_gap_%0d", k), {31'b0, bus.wbm_cyc_o}, 32'h0);
        end
        set_req_i(1'b0);
        set_req_d(1'b0);

        // data write
        step();
        set_req_d(1'b1);
        bus.dwbs_we_i  = 1'b1;
        bus.dwbs_sel_i = 4'b0011;
        bus.dwbs_dat_i = 32'hDEAD_BEEF;
        step();
        sample();
        check("wr_dat", bus.wbm_dat_o, 32'hDEAD_BEEF);
        check("wr_we_sel", {27'b0, bus.wbm_we_o, bus.wbm_sel_o}, 32'h0000_0013);
        check("wr_addr", bus.wbm_addr_o, DADDR);
        step();
        bus.wbm_ack_i = 1'b1;
        sample();
        check("wr_ack", {30'b0, bus.iwbs_ack_o, bus.dwbs_ack_o}, 32'h1);
        step();
        bus.wbm_ack_i = 1'b0;
        clear_inputs();

        // watchdog fires on the fourth grant cycle
        step();
        set_req_d(1'b1);
        step();
        step();
        step();
        sample();
        check("wd_c3_quiet", {30'b0, bus.timeout_o, bus.dwbs_err_o}, 32'h0);
        step();
        sample();
        check("wd_fire", {29'b0, bus.timeout_o, bus.dwbs_err_o, bus.iwbs_err_o}, 32'h6);
        check("wd_fire_cyc", {30'b0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h0);
        step();
        set_req_d(1'b0);
        set_req_i(1'b1);
        sample();
        check("wd_after_idle", {30'b0, bus.wbm_cyc_o, bus.timeout_o}, 32'h0);
        step();
        sample();
        check("wd_i_gnt", bus.wbm_addr_o, IADDR);
        step();
        bus.wbm_ack_i = 1'b1;
        sample();
        check("wd_i_ack", {30'b0, bus.iwbs_ack_o, bus.iwbs_err_o}, 32'h2);
        step();
        bus.wbm_ack_i = 1'b0;
        set_req_i(1'b0);

        // ack on the expiry cycle wins over the watchdog
        step();
        set_req_d(1'b1);
        step();
        step();
        step();
        step();
        bus.wbm_ack_i = 1'b1;
        sample();
        check("wd_race", {29'b0, bus.dwbs_ack_o, bus.dwbs_err_o, bus.timeout_o}, 32'h4);
        step();
        bus.wbm_ack_i = 1'b0;
        set_req_d(1'b0);

        // asynchronous reset in the middle of a grant
        step();
        set_req_i(1'b1);
        step();
        sample();
        check("arst_pre_cyc", {31'b0, bus.wbm_cyc_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cyc", {30'b0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h0);
        check("arst_outs", {27'b0, bus.wbm_sel_o, bus.timeout_o}, 32'h0);
        check("arst_addr", bus.wbm_addr_o, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        sample();
        check("arst_regrant", {31'b0, bus.wbm_cyc_o}, 32'h1);
        check("arst_regrant_addr", bus.wbm_addr_o, IADDR);
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master-to-one-slave Wishbone (classic, single-transfer) arbiter placed directly downstream of the core's instruction and data master ports.
- Merges both ports onto a single system bus with round-robin arbitration.
- Includes a bus watchdog that terminates hung transfers with an error response.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transfer may wait for ack/err before the watchdog fires; 0 disables the watchdog.
- FIRST_PRIORITY_D, 1: side that wins a simultaneous request when no transfer has been served yet since reset (1 = data, 0 = instruction).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- iwbs_cyc_i  in  1  instruction-port cycle
- iwbs_stb_i  in  1  instruction-port strobe
- iwbs_addr_i  in  32  instruction-port address
- iwbs_dat_o  out  32  instruction read data
- iwbs_ack_o  out  1  instruction-port ack
- iwbs_err_o  out  1  instruction-port error
- dwbs_cyc_i  in  1  data-port cycle
- dwbs_stb_i  in  1  data-port strobe
- dwbs_we_i  in  1  data-port write enable
- dwbs_sel_i  in  4  data-port byte select
- dwbs_addr_i  in  32  data-port address
- dwbs_dat_i  in  32  data write data
- dwbs_dat_o  out  32  data read data
- dwbs_ack_o  out  1  data-port ack
- dwbs_err_o  out  1  data-port error
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  bus strobe
- wbm_we_o  out  1  bus write enable
- wbm_sel_o  out  4  bus byte select
- wbm_addr_o  out  32  bus address
- wbm_dat_o  out  32  bus write data
- wbm_dat_i  in  32  bus read data
- wbm_ack_i  in  1  bus ack
- wbm_err_i  in  1  bus error
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, last_served=none, watchdog counter=0.
  - All outputs 0 (combinational from state), including timeout_o.
- States: IDLE, GNT_I, GNT_D (registered).
- Request: req_x = xwbs_cyc_i & xwbs_stb_i.
- IDLE transitions (registered):
  - Only one side requests -> grant that side.
  - Both request -> grant the side not served last. If nothing has been served yet, grant per FIRST_PRIORITY_D.
  - Grant latency: one cycle. wbm_cyc_o/stb_o assert in the first GNT cycle.
- While in GNT_x:
  - wbm_* outputs are a combinational mux of the granted port.
  - Instruction grant forces wbm_we_o=0, wbm_sel_o=4'hF, wbm_dat_o=0.
  - wbm_dat_i is routed to both iwbs_dat_o and dwbs_dat_o unconditionally.
  - wbm_ack_i/err_i go to the granted port only; the non-granted port's ack/err stay 0.
- Completion:
  - Cycle with wbm_ack_i|wbm_err_i in GNT_x -> next state IDLE, last_served=x.
  - Consequence: minimum one idle bus cycle between transfers (3-cycle best case per transfer with zero-wait slave).
- Abort: granted port drops cyc_i while in GNT_x -> wbm_cyc_o/stb_o fall in the same cycle (mux) and the next state is IDLE. last_served is unchanged and no ack is forwarded.
- Ignored signals: wbm_ack_i/err_i arriving in IDLE are ignored; they never reach either port.
- Watchdog:
  - Counter cleared on entering GNT_x and increments every GNT cycle without ack/err.
  - Width is clog2(TIMEOUT_CYCLES+1).
  - When count==TIMEOUT_CYCLES-1 and no ack/err is present:
    - assert xwbs_err_o to the granted port for that cycle;
    - pulse timeout_o;
    - force wbm_cyc_o/stb_o=0 that cycle;
    - next state IDLE, last_served=x.
  - Ack/err on the same cycle as expiry: the bus response wins, and neither timeout_o nor the synthetic err is generated.
  - TIMEOUT_CYCLES=0: counter never fires.
- Bus error: wbm_err_i is forwarded as an ordinary termination, identical to ack for state purposes.
- Reset mid-transfer: immediate IDLE and all outputs 0; the slave is expected to tolerate the dropped cyc.
- Stability: request signals are sampled only in IDLE. Changes of addr/we/sel during a grant pass through unchanged, with no latching.

Decomposition:
- Shared package (defines include):
  - state encodings ST_IDLE, ST_GNT_I, ST_GNT_D;
  - last-served encodings LS_NONE, LS_I, LS_D;
  - SEL_ALL = 4'hF.
- Sub-module wb_watchdog: counter with clear/enable/expire inputs and outputs, parameterised by TIMEOUT_CYCLES.
- Arbitration FSM and mux stay in the top module.

Test Plan:
- Instruction-only read, addr 0x8000_0000, slave acks at cycle 2 of grant with 0x0000_0013 -> iwbs_dat_o=0x13 and iwbs_ack_o pulses once; dwbs_ack_o stays 0; wbm_we_o=0, wbm_sel_o=F.
- Both request in the same cycle after reset (FIRST_PRIORITY_D=1) -> data granted first. The instruction request held high is granted on the cycle after data's ack+1 idle; both complete.
- Both held requesting continuously for 6 transfers -> grant sequence D,I,D,I,D,I, with no starvation.
- Data write 0xDEADBEEF to 0x1000_0004, sel=4'b0011 -> wbm_dat_o/sel_o/we_o match during grant; ack goes only to dwbs.
- TIMEOUT_CYCLES=4, slave never acks a data read -> dwbs_err_o and timeout_o pulse together on the 4th grant cycle, bus is IDLE next cycle, and a subsequent instruction request is served normally. Repeat with ack on that same cycle -> ack delivered, no timeout_o.
- Assert rst_i=0 mid-grant (asynchronously, between clock edges) -> wbm_cyc_o drops immediately and all outputs are 0. After release, a pending instruction request is granted within 1 cycle.
